// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter that shares one single-cycle-ack MMIO slave among N masters.
// The owner keeps the bus while it holds CYC. A watchdog error-terminates a strobe the slave never acknowledges.
module wb_rr_arbiter #(
  parameter int N       = 2,
  parameter int AW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    m_cyc,
  input  logic [N-1:0]    m_stb,
  input  logic [N-1:0]    m_we,
  input  logic [N*AW-1:0] m_adr,
  input  logic [N*32-1:0] m_dat_w,
  output logic [31:0]     m_dat_r,
  output logic [N-1:0]    m_ack,
  output logic [N-1:0]    m_err,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [31:0]     s_dat_w,
  input  logic [31:0]     s_dat_r,
  input  logic            s_ack,
  output logic [N-1:0]    grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_nextOwner;
  logic [IW-1:0] r_lastGrant;
  logic [IW-1:0] w_nextLast;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_nextCount;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic [IW:0]   w_scan;
  logic          w_ownCyc;
  logic          w_ownStb;
  logic          w_stall;

  assign w_ownCyc = m_cyc[r_owner];
  assign w_ownStb = m_stb[r_owner];
  assign w_stall  = (r_state == OWN) && w_ownCyc && w_ownStb && !s_ack;
  assign m_dat_r  = s_dat_r;

  // Rotating priority: the master just after the last owner is scanned first.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_lastGrant;
    w_scan  = '0;
    for (int k = 1; k <= N; k++) begin
      w_scan = {1'b0, r_lastGrant} + (IW+1)'(k);
      if (w_scan >= (IW+1)'(N)) begin
        w_scan = w_scan - (IW+1)'(N);
      end
      if (!w_found && m_cyc[w_scan[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_scan[IW-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_lastGrant <= IW'(N - 1);
      r_count     <= '0;
    end else begin
      r_state     <= w_nextState;
      r_owner     <= w_nextOwner;
      r_lastGrant <= w_nextLast;
      r_count     <= w_nextCount;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextOwner = r_owner;
    w_nextLast  = r_lastGrant;
    w_nextCount = r_count;
    unique case (r_state)
      IDLE: begin
        w_nextCount = '0;
        if (w_found) begin
          w_nextState = OWN;
          w_nextOwner = w_pick;
          w_nextLast  = w_pick;
        end
      end
      OWN: begin
        if (!w_ownCyc) begin
          w_nextState = IDLE;
          w_nextCount = '0;
        end else if (w_stall) begin
          // The stall that would bring the count to TIMEOUT ends the cycle with an error.
          if (r_count == CW'(TIMEOUT - 1)) begin
            w_nextState = ERR;
            w_nextCount = '0;
          end else begin
            w_nextCount = r_count + CW'(1);
          end
        end else begin
          w_nextCount = '0;
        end
      end
      ERR: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCount = '0;
      end
    endcase
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    m_ack   = '0;
    m_err   = '0;
    grant   = '0;
    case (r_state)
      OWN: begin
        s_cyc          = w_ownCyc;
        s_stb          = w_ownCyc & w_ownStb;
        s_we           = m_we[r_owner];
        s_adr          = m_adr[r_owner*AW +: AW];
        s_dat_w        = m_dat_w[r_owner*32 +: 32];
        m_ack[r_owner] = s_ack & w_ownCyc;
        grant[r_owner] = 1'b1;
      end
      ERR: begin
        m_err[r_owner] = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: three concurrent masters against a registered single-cycle-ack slave model.
module tb_wb_rr_arbiter;

  localparam int N       = 3;
  localparam int AW      = 8;
  localparam int TIMEOUT = 16;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*32-1:0] m_dat_w;
  logic [31:0]     m_dat_r;
  logic [N-1:0]    m_ack, m_err, grant;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [31:0]     s_dat_w;
  logic [31:0]     s_dat_r;
  logic            s_ack;

  logic            mCyc [N];
  logic            mStb [N];
  logic            mWe  [N];
  logic [AW-1:0]   mAdr [N];
  logic [31:0]     mDat [N];

  logic            slaveEn;
  logic            strayAck;
  logic [31:0]     slaveRdData;
  logic            monEn;
  int              cycleNo = 0;
  int              testsRun = 0;
  int              testsFailed = 0;
  int              errWait;
  int              t;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [31:0]  dat;
  } ackExp_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } slvExp_t;

  ackExp_t      expAck [$];
  slvExp_t      expSlv [$];
  logic [N-1:0] expGrant [$];
  logic [N-1:0] expErr [$];
  int           grantRise [$];
  int           ackCyc [$];
  int           errCyc [$];
  logic [N-1:0] prevGrant;
  ackExp_t      eAck;
  slvExp_t      eSlv;

  wb_rr_arbiter #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .grant(grant)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleNo <= cycleNo + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_cyc[i]            = mCyc[i];
      m_stb[i]            = mStb[i];
      m_we[i]             = mWe[i];
      m_adr[i*AW +: AW]   = mAdr[i];
      m_dat_w[i*32 +: 32] = mDat[i];
    end
  end

  // Slave model: acknowledges a strobe one cycle later, never two cycles in a row.
  always @(posedge CLK) begin
    if (slaveEn && s_cyc && s_stb && !s_ack) begin
      s_ack   <= 1'b1;
      s_dat_r <= s_we ? 32'h0 : slaveRdData;
    end else begin
      s_ack   <= strayAck;
      s_dat_r <= 32'h0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushAck(input logic [N-1:0] ackVec, input logic [31:0] dat);
    ackExp_t e;
    e.ack = ackVec;
    e.dat = dat;
    expAck.push_back(e);
  endtask

  task automatic pushSlv(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat);
    slvExp_t e;
    e.we  = we;
    e.adr = adr;
    e.dat = dat;
    expSlv.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One master: holds CYC for nXfer strobes (adr/dat step by one per strobe), drops CYC after the last ack or an error.
  task automatic applyStimulus(input int m, input int nXfer, input logic we,
                               input logic [AW-1:0] adr, input logic [31:0] dat);
    int budget;
    logic gotErr;
    gotErr  = 1'b0;
    mCyc[m] = 1'b1;
    mStb[m] = 1'b1;
    mWe[m]  = we;
    for (int x = 0; x < nXfer; x++) begin
      mAdr[m] = adr + AW'(x);
      mDat[m] = dat + 32'(x);
      budget  = 0;
      do begin
        @(negedge CLK);
        budget++;
      end while (m_ack[m] !== 1'b1 && m_err[m] !== 1'b1 && budget < 100);
      if (budget >= 100) begin
        checkOutput("ackWait", m_ack[m], 1);
        break;
      end
      gotErr = m_err[m];
      @(posedge CLK);
      #1;
      if (gotErr) break;
    end
    mCyc[m] = 1'b0;
    mStb[m] = 1'b0;
  endtask

  // Monitor: pops the scoreboards whenever the DUT grants, acks or errors.
  always @(negedge CLK) begin
    if (monEn) begin
      if (grant != '0 && prevGrant == '0) begin
        grantRise.push_back(cycleNo);
        if (expGrant.size() == 0) checkOutput("unexpGrant", grant, 0);
        else checkOutput("grant", grant, expGrant.pop_front());
        checkOutput("sCycAtGrant", s_cyc, 1);
      end
      if (m_ack != '0) begin
        ackCyc.push_back(cycleNo);
        if (expAck.size() == 0) checkOutput("unexpAck", m_ack, 0);
        else begin
          eAck = expAck.pop_front();
          checkOutput("mAck", m_ack, eAck.ack);
          checkOutput("mDatR", m_dat_r, eAck.dat);
        end
      end
      if (m_err != '0) begin
        errCyc.push_back(cycleNo);
        if (expErr.size() == 0) checkOutput("unexpErr", m_err, 0);
        else checkOutput("mErr", m_err, expErr.pop_front());
        checkOutput("sCycInErr", s_cyc, 0);
        checkOutput("sStbInErr", s_stb, 0);
        checkOutput("grantInErr", grant, 0);
      end
      if (s_cyc && s_stb && s_ack) begin
        if (expSlv.size() == 0) checkOutput("unexpSlave", s_adr, 0);
        else begin
          eSlv = expSlv.pop_front();
          checkOutput("sWe", s_we, eSlv.we);
          checkOutput("sAdr", s_adr, eSlv.adr);
          if (eSlv.we) checkOutput("sDatW", s_dat_w, eSlv.dat);
        end
      end
    end
    prevGrant <= grant;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: observed cycle %0d, expected end before it", cycleNo);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    RST = 1'b1; slaveEn = 1'b0; strayAck = 1'b0; slaveRdData = 32'h0; monEn = 1'b0;
    for (int i = 0; i < N; i++) begin
      mCyc[i] = 1'b0; mStb[i] = 1'b0; mWe[i] = 1'b0; mAdr[i] = '0; mDat[i] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstSCyc", s_cyc, 0);
    checkOutput("rstSStb", s_stb, 0);
    checkOutput("rstSAdr", s_adr, 0);
    checkOutput("rstSDatW", s_dat_w, 0);
    checkOutput("rstMAck", m_ack, 0);
    checkOutput("rstMErr", m_err, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0; monEn = 1'b1; slaveEn = 1'b1;
    idleCycles(1);

    // Single write from master 0 after reset.
    grantRise.delete(); ackCyc.delete();
    t = cycleNo;
    expGrant.push_back(3'b001); pushAck(3'b001, 32'h0); pushSlv(1'b1, 8'h04, 32'h000000A5);
    applyStimulus(0, 1, 1'b1, 8'h04, 32'h000000A5);
    checkOutput("t1GrantLat", grantRise[0] - t, 1);
    checkOutput("t1AckLat", ackCyc[0] - t, 2);
    idleCycles(2);

    // Master 2 write, leaving master 2 as the last owner.
    expGrant.push_back(3'b100); pushAck(3'b100, 32'h0); pushSlv(1'b1, 8'h30, 32'h12345678);
    applyStimulus(2, 1, 1'b1, 8'h30, 32'h12345678);
    idleCycles(2);

    // All three request together, then master 0 again.
    grantRise.delete();
    for (int i = 0; i < N; i++) begin
      expGrant.push_back(N'(1 << i)); pushAck(N'(1 << i), 32'h0);
      pushSlv(1'b1, AW'(8'h10 + i), 32'h100 + 32'(i));
    end
    expGrant.push_back(3'b001); pushAck(3'b001, 32'h0); pushSlv(1'b1, 8'h20, 32'h200);
    fork
      applyStimulus(0, 1, 1'b1, 8'h10, 32'h100);
      applyStimulus(1, 1, 1'b1, 8'h11, 32'h101);
      applyStimulus(2, 1, 1'b1, 8'h12, 32'h102);
    join
    applyStimulus(0, 1, 1'b1, 8'h20, 32'h200);
    checkOutput("t2Gap01", grantRise[1] - grantRise[0], 4);
    checkOutput("t2Gap12", grantRise[2] - grantRise[1], 4);
    checkOutput("t2Gap20", grantRise[3] - grantRise[2], 4);
    idleCycles(2);

    // Master 1 holds CYC for four strobes while master 0 waits.
    grantRise.delete(); ackCyc.delete();
    t = cycleNo;
    expGrant.push_back(3'b010); expGrant.push_back(3'b001);
    for (int x = 0; x < 4; x++) begin
      pushAck(3'b010, 32'h0); pushSlv(1'b1, AW'(8'h40 + x), 32'hB0 + 32'(x));
    end
    pushAck(3'b001, 32'h0); pushSlv(1'b1, 8'h50, 32'hC0);
    fork
      applyStimulus(1, 4, 1'b1, 8'h40, 32'hB0);
      begin
        idleCycles(2);
        applyStimulus(0, 1, 1'b1, 8'h50, 32'hC0);
      end
    join
    checkOutput("t3LastAck", ackCyc[3] - t, 8);
    checkOutput("t3WaitAfterDrop", grantRise[1] - (ackCyc[3] + 1), 2);
    idleCycles(2);

    // Slave never acks master 1: watchdog error, then master 2 is served.
    grantRise.delete(); errCyc.delete();
    slaveEn = 1'b0;
    expGrant.push_back(3'b010); expGrant.push_back(3'b100); expErr.push_back(3'b010);
    pushAck(3'b100, 32'h0); pushSlv(1'b1, 8'h70, 32'hE0);
    fork
      applyStimulus(1, 1, 1'b0, 8'h60, 32'h0);
      begin
        idleCycles(2);
        applyStimulus(2, 1, 1'b1, 8'h70, 32'hE0);
      end
      begin
        errWait = 0;
        while (m_err == '0 && errWait < 60) begin
          @(negedge CLK);
          errWait++;
        end
        slaveEn = 1'b1;
      end
    join
    checkOutput("t4ErrDelay", errCyc[0] - grantRise[0], TIMEOUT);
    checkOutput("t4NextGrant", grantRise[1] - errCyc[0], 2);
    idleCycles(2);

    // Read returning 0xDEADBEEF to master 0.
    slaveRdData = 32'hDEADBEEF;
    expGrant.push_back(3'b001); pushAck(3'b001, 32'hDEADBEEF); pushSlv(1'b0, 8'h08, 32'h0);
    applyStimulus(0, 1, 1'b0, 8'h08, 32'h0);
    idleCycles(2);

    // A slave ack while the bus is idle must not reach any master.
    strayAck = 1'b1;
    idleCycles(1);
    strayAck = 1'b0;
    @(negedge CLK);
    checkOutput("strayAckSeen", s_ack, 1);
    checkOutput("strayAckMAck", m_ack, 0);
    idleCycles(2);

    // Reset while master 0 owns the bus with a stalled strobe.
    slaveEn = 1'b0;
    expGrant.push_back(3'b001);
    mCyc[0] = 1'b1; mStb[0] = 1'b1; mWe[0] = 1'b1; mAdr[0] = 8'h0C; mDat[0] = 32'h77;
    idleCycles(3);
    @(negedge CLK);
    checkOutput("t7StbBeforeRst", s_stb, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("t7SyncRstGrant", grant, 3'b001);
    @(posedge CLK);
    #1;
    RST = 1'b0; mCyc[0] = 1'b0; mStb[0] = 1'b0;
    @(negedge CLK);
    checkOutput("t7Grant", grant, 0);
    checkOutput("t7SCyc", s_cyc, 0);
    checkOutput("t7SStb", s_stb, 0);
    checkOutput("t7SAdr", s_adr, 0);
    checkOutput("t7SDatW", s_dat_w, 0);
    checkOutput("t7MAck", m_ack, 0);
    checkOutput("t7MErr", m_err, 0);
    slaveEn = 1'b1;
    idleCycles(1);
    expGrant.push_back(3'b001); expGrant.push_back(3'b010);
    pushAck(3'b001, 32'h0); pushSlv(1'b1, 8'h80, 32'hF0);
    pushAck(3'b010, 32'h0); pushSlv(1'b1, 8'h90, 32'hF1);
    fork
      applyStimulus(0, 1, 1'b1, 8'h80, 32'hF0);
      applyStimulus(1, 1, 1'b1, 8'h90, 32'hF1);
    join
    idleCycles(3);

    checkOutput("drainGrant", expGrant.size(), 0);
    checkOutput("drainAck", expAck.size(), 0);
    checkOutput("drainSlave", expSlv.size(), 0);
    checkOutput("drainErr", expErr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
